// File: rtl/parity_prefix_pkg.sv
// Shared helpers for the prefix-parity unit.
// Provides the ceil(log2) used to size the prefix network.
package parity_prefix_pkg;

    // ceil(log2(n)); returns 0 for n <= 1.
    function automatic int pp_clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/parity_prefix_ref.sv
// Linear ripple prefix parity: owv_out[i] = ^iwv_in[i:0].
// Ports: iwv_in operand, owv_out prefix parity (combinational).
module parity_prefix_ref #(
    parameter int p_WIDTH = 8
) (
    input  logic [p_WIDTH-1:0] iwv_in,
    output logic [p_WIDTH-1:0] owv_out
);

    logic acc;

    always_comb begin
        owv_out = '0;
        acc     = 1'b0;
        for (int i = 0; i < p_WIDTH; i++) begin
            acc        = acc ^ iwv_in[i];
            owv_out[i] = acc;
        end
    end

endmodule

// File: rtl/parity_prefix.sv
// Registered prefix parity (XOR scan) via a Sklansky network.
// Ports: i_clk, i_rst_n (sync, active-low), i_valid/iwv_in in,
//        o_valid/owv_out registered result, 1-cycle latency.
module parity_prefix
    import parity_prefix_pkg::*;
#(
    parameter int p_WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [p_WIDTH-1:0] iwv_in,
    output logic               o_valid,
    output logic [p_WIDTH-1:0] owv_out
);

    localparam int LEVELS = pp_clog2(p_WIDTH);

    logic [p_WIDTH-1:0] pfx;

    // Level k merges blocks of 2^k: a bit with index bit k set
    // absorbs the prefix ending just below its 2^(k+1)-aligned half.
    genvar k, i;
    generate
        for (k = 0; k < LEVELS; k++) begin : g_lvl
            logic [p_WIDTH-1:0] prv;
            logic [p_WIDTH-1:0] nxt;

            if (k == 0) begin : g_first
                assign prv = iwv_in;
            end else begin : g_chain
                assign prv = g_lvl[k-1].nxt;
            end

            for (i = 0; i < p_WIDTH; i++) begin : g_bit
                if (((i >> k) & 1) == 1) begin : g_mix
                    assign nxt[i] = prv[i] ^ prv[((i >> k) << k) - 1];
                end else begin : g_pass
                    assign nxt[i] = prv[i];
                end
            end
        end

        if (LEVELS == 0) begin : g_wire
            assign pfx = iwv_in;
        end else begin : g_tap
            assign pfx = g_lvl[LEVELS-1].nxt;
        end
    endgenerate

    // owv_out holds its last value when no operand arrives.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            owv_out <= '0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) owv_out <= pfx;
        end
    end

endmodule

// File: tb/tb_parity_prefix.sv
// Self-checking bench for parity_prefix at widths 1, 4, 8 and 12.
// Model derives prefix parity by masked reduction of the operand.
module tb_parity_prefix;

    logic        clk;
    logic        rst_n;
    logic        vin;
    logic [11:0] din;

    logic        ov1, ov4, ov8, ov12;
    logic [0:0]  o1;
    logic [3:0]  o4;
    logic [7:0]  o8;
    logic [11:0] o12;

    int n_run;
    int n_fail;
    bit chk_en;

    parity_prefix #(.p_WIDTH(1)) u_w1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin),
        .iwv_in(din[0:0]), .o_valid(ov1), .owv_out(o1)
    );
    parity_prefix #(.p_WIDTH(4)) u_w4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin),
        .iwv_in(din[3:0]), .o_valid(ov4), .owv_out(o4)
    );
    parity_prefix #(.p_WIDTH(8)) u_w8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin),
        .iwv_in(din[7:0]), .o_valid(ov8), .owv_out(o8)
    );
    parity_prefix #(.p_WIDTH(12)) u_w12 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin),
        .iwv_in(din), .o_valid(ov12), .owv_out(o12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit i of the result is the parity of the operand masked to bits 0..i.
    function automatic logic [63:0] pfx(input logic [63:0] x, input int w);
        logic [63:0] r;
        logic [63:0] m;
        r = '0;
        for (int b = 0; b < w; b++) begin
            m    = (64'd1 << (b + 1)) - 64'd1;
            r[b] = ^(x & m);
        end
        return r;
    endfunction

    int          wid [4] = '{1, 4, 8, 12};
    logic        m_v;
    logic [63:0] m_out [4];
    logic [63:0] act [4];
    logic        act_v [4];

    // Expected results one cycle behind the sampled inputs.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_v <= 1'b0;
            for (int j = 0; j < 4; j++) m_out[j] <= '0;
        end else begin
            m_v <= vin;
            if (vin) begin
                for (int j = 0; j < 4; j++)
                    m_out[j] <= pfx({52'd0, din}, wid[j]);
            end
        end
    end

    always_comb begin
        act[0]   = {63'd0, o1};
        act[1]   = {60'd0, o4};
        act[2]   = {56'd0, o8};
        act[3]   = {52'd0, o12};
        act_v[0] = ov1;
        act_v[1] = ov4;
        act_v[2] = ov8;
        act_v[3] = ov12;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int j = 0; j < 4; j++) begin
                n_run++;
                if (act_v[j] !== m_v || act[j] !== m_out[j]) begin
                    n_fail++;
                    $display("FAIL model w%0d: got v=%b out=%h, want v=%b out=%h",
                             wid[j], act_v[j], act[j], m_v, m_out[j]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] a,
                       input logic [63:0] e);
        n_run++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, a, e);
        end
    endtask

    task automatic apply(input logic [11:0] x, input logic v);
        din = x;
        vin = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        vin    = 1'b0;
        din    = '0;

        // Reset wins over a valid operand.
        apply(12'h0FF, 1'b1);
        apply(12'h0FF, 1'b1);
        chk_en = 1'b1;
        chk("rst_v8", {63'd0, ov8}, 64'd0);
        chk("rst_o8", {56'd0, o8}, 64'd0);
        chk("rst_o12", {52'd0, o12}, 64'd0);

        rst_n = 1'b1;
        apply(12'h0FF, 1'b1);
        chk("rel_v8", {63'd0, ov8}, 64'd1);
        chk("rel_o8", {56'd0, o8}, 64'h55);

        // Width-4 directed values.
        apply(12'h00B, 1'b1);
        chk("w4_1011", {60'd0, o4}, 64'b1001);
        apply(12'h001, 1'b1);
        chk("w4_0001", {60'd0, o4}, 64'b1111);
        chk("w8_01", {56'd0, o8}, 64'hFF);
        apply(12'h008, 1'b1);
        chk("w4_1000", {60'd0, o4}, 64'b1000);
        apply(12'h00F, 1'b1);
        chk("w4_1111", {60'd0, o4}, 64'b0101);
        apply(12'h000, 1'b1);
        chk("w4_0000", {60'd0, o4}, 64'b0000);

        // Valid gating holds the last result.
        apply(12'h001, 1'b1);
        chk("gate_o8a", {56'd0, o8}, 64'hFF);
        apply(12'h0AA, 1'b0);
        chk("gate_v8", {63'd0, ov8}, 64'd0);
        chk("gate_o8b", {56'd0, o8}, 64'hFF);
        chk("w1_v_low", {63'd0, ov1}, 64'd0);

        // Width 1: o_valid rises one cycle after i_valid.
        apply(12'h001, 1'b1);
        chk("w1_v_up", {63'd0, ov1}, 64'd1);
        chk("w1_one", {63'd0, o1}, 64'd1);
        apply(12'h000, 1'b1);
        chk("w1_zero", {63'd0, o1}, 64'd0);

        // Back-to-back stream.
        apply(12'h001, 1'b1);
        chk("strm_0", {56'd0, o8}, 64'hFF);
        apply(12'h003, 1'b1);
        chk("strm_1", {56'd0, o8}, 64'h01);
        apply(12'h080, 1'b1);
        chk("strm_2", {56'd0, o8}, 64'h80);
        chk("strm_v", {63'd0, ov8}, 64'd1);

        // Mid-stream reset drops the pending result.
        rst_n = 1'b0;
        apply(12'h0F0, 1'b1);
        chk("mid_rst_v", {63'd0, ov8}, 64'd0);
        chk("mid_rst_o", {52'd0, o12}, 64'd0);
        rst_n = 1'b1;

        // Pin the model against hand values.
        chk("mdl_w12", pfx(64'hFFF, 12), 64'h555);
        chk("mdl_w8", pfx(64'h0B, 8), 64'hF9);

        // Exhaustive sweep; each width sees all its operands.
        for (int n = 0; n < 4096; n++) begin
            apply(n[11:0], 1'b1);
        end
        apply(12'h000, 1'b0);
        @(negedge clk);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
